// File: rtl/tt_switch_pkg.sv
// Shared types and defaults for the Tiny-Tapeout style project switch.
package tt_switch_pkg;

    localparam int DEF_N_PROJ   = 4;
    localparam int DEF_IO_W     = 8;
    localparam int DEF_RST_HOLD = 4;

    typedef enum logic [1:0] {
        ST_ISOLATE = 2'd0,
        ST_HOLD    = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    // Select width; kept at least 1 bit so the ports never collapse to zero width.
    function automatic int sel_w(input int n_proj);
        return (n_proj <= 2) ? 1 : $clog2(n_proj);
    endfunction

endpackage

// File: rtl/tt_io_mux.sv
// N_PROJ:1 slice mux of the project pad buses with a force-to-zero override.
module tt_io_mux #(
    parameter int N_PROJ = 4,
    parameter int IO_W   = 8,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]       sel,
    input  logic                   force_zero,
    input  logic [N_PROJ*IO_W-1:0] proj_uo_out,
    input  logic [N_PROJ*IO_W-1:0] proj_uio_out,
    input  logic [N_PROJ*IO_W-1:0] proj_uio_oe,
    output logic [IO_W-1:0]        uo_out,
    output logic [IO_W-1:0]        uio_out,
    output logic [IO_W-1:0]        uio_oe
);

    always_comb begin
        uo_out  = '0;
        uio_out = '0;
        uio_oe  = '0;
        if (!force_zero) begin
            for (int k = 0; k < N_PROJ; k++) begin
                if (sel == SEL_W'(k)) begin
                    uo_out  = proj_uo_out[k*IO_W +: IO_W];
                    uio_out = proj_uio_out[k*IO_W +: IO_W];
                    uio_oe  = proj_uio_oe[k*IO_W +: IO_W];
                end
            end
        end
    end

endmodule

// File: rtl/tt_project_switch.sv
// Project switch: isolate, hold-in-reset, then hand the pads to the selected project.
// Define TT_PROJECT_SWITCH_OUT_REG_EN to register the pad outputs.
module tt_project_switch
    import tt_switch_pkg::*;
#(
    parameter int N_PROJ   = DEF_N_PROJ,
    parameter int IO_W     = DEF_IO_W,
    parameter int RST_HOLD = DEF_RST_HOLD,
    parameter int DEF_SEL  = 0,
    localparam int SEL_W   = sel_w(N_PROJ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       sel_req,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    output logic                   sel_err,
    output logic [SEL_W-1:0]       active_sel,
    output logic                   switching,
    input  logic [N_PROJ*IO_W-1:0] proj_uo_out,
    input  logic [N_PROJ*IO_W-1:0] proj_uio_out,
    input  logic [N_PROJ*IO_W-1:0] proj_uio_oe,
    output logic [N_PROJ-1:0]      proj_rst_n,
    output logic [IO_W-1:0]        uo_out,
    output logic [IO_W-1:0]        uio_out,
    output logic [IO_W-1:0]        uio_oe
);

    localparam logic [7:0]        HOLD_LD   = 8'(RST_HOLD);
    localparam logic [SEL_W-1:0]  DEF_SEL_V = SEL_W'(DEF_SEL);
    localparam logic [N_PROJ-1:0] ONE_HOT0  = N_PROJ'(1);

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [SEL_W-1:0]  active_sel_q;
    logic [SEL_W-1:0]  pend_q;
    logic [N_PROJ-1:0] rst_n_q;
    logic              sel_err_q;
    logic              req_in_range;

    assign req_in_range = 32'(sel_req) < 32'(N_PROJ);

    // Handshake: a request is taken on any edge where sel_valid && sel_ready;
    // sel_ready is high only in ACTIVE, so requests elsewhere are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= HOLD_LD;
            active_sel_q <= DEF_SEL_V;
            pend_q       <= DEF_SEL_V;
            rst_n_q      <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            sel_err_q <= 1'b0;
            case (state_q)
                ST_ACTIVE: begin
                    if (sel_valid) begin
                        if (req_in_range) begin
                            state_q <= ST_ISOLATE;
                            pend_q  <= sel_req;
                            rst_n_q <= '0;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                ST_ISOLATE: begin
                    state_q      <= ST_HOLD;
                    cnt_q        <= HOLD_LD;
                    active_sel_q <= pend_q;
                end
                ST_HOLD: begin
                    // The cycle seen with cnt_q==1 is the last of RST_HOLD hold cycles.
                    if (cnt_q <= 8'd1) begin
                        state_q <= ST_ACTIVE;
                        rst_n_q <= ONE_HOT0 << active_sel_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= HOLD_LD;
                    rst_n_q <= '0;
                end
            endcase
        end
    end

    assign sel_ready  = (state_q == ST_ACTIVE);
    assign switching  = (state_q != ST_ACTIVE);
    assign sel_err    = sel_err_q;
    assign active_sel = active_sel_q;
    assign proj_rst_n = rst_n_q;

    logic [IO_W-1:0] mux_uo, mux_uio, mux_oe;

    tt_io_mux #(
        .N_PROJ (N_PROJ),
        .IO_W   (IO_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel          (active_sel_q),
        .force_zero   (state_q != ST_ACTIVE),
        .proj_uo_out  (proj_uo_out),
        .proj_uio_out (proj_uio_out),
        .proj_uio_oe  (proj_uio_oe),
        .uo_out       (mux_uo),
        .uio_out      (mux_uio),
        .uio_oe       (mux_oe)
    );

`ifdef TT_PROJECT_SWITCH_OUT_REG_EN
    logic [IO_W-1:0] uo_q, uio_q, oe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            uo_q  <= '0;
            uio_q <= '0;
            oe_q  <= '0;
        end else begin
            uo_q  <= mux_uo;
            uio_q <= mux_uio;
            oe_q  <= mux_oe;
        end
    end

    // Drop output enables immediately in ISOLATE so the next project never fights the pads.
    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = (state_q == ST_ISOLATE) ? '0 : oe_q;
`else
    assign uo_out  = mux_uo;
    assign uio_out = mux_uio;
    assign uio_oe  = mux_oe;
`endif

endmodule

// File: tb/tb_tt_project_switch.sv
// Directed bench for tt_project_switch: reset, switching, restart, error and mid-switch reset.
module tb_tt_project_switch;

`ifdef TT_PROJECT_SWITCH_OUT_REG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Main instance: N_PROJ=4, RST_HOLD=4, DEF_SEL=2.
    logic [1:0]  m_sel_req = '0;
    logic        m_sel_valid = 1'b0;
    logic        m_sel_ready, m_sel_err, m_switching;
    logic [1:0]  m_active_sel;
    logic [31:0] m_uo_in, m_uio_in, m_oe_in;
    logic [3:0]  m_rst_n;
    logic [7:0]  m_uo, m_uio, m_oe;

    tt_project_switch #(.N_PROJ(4), .IO_W(8), .RST_HOLD(4), .DEF_SEL(2)) dut (
        .clk(clk), .rst(rst), .sel_req(m_sel_req), .sel_valid(m_sel_valid),
        .sel_ready(m_sel_ready), .sel_err(m_sel_err), .active_sel(m_active_sel),
        .switching(m_switching), .proj_uo_out(m_uo_in), .proj_uio_out(m_uio_in),
        .proj_uio_oe(m_oe_in), .proj_rst_n(m_rst_n), .uo_out(m_uo),
        .uio_out(m_uio), .uio_oe(m_oe)
    );

    // A 2-bit select cannot carry index 5, so out-of-range is exercised on a
    // 3-project instance where index 3 fits the port but names no project.
    logic [1:0]  s_sel_req = '0;
    logic        s_sel_valid = 1'b0;
    logic        s_sel_ready, s_sel_err, s_switching;
    logic [1:0]  s_active_sel;
    logic [23:0] s_uo_in, s_uio_in, s_oe_in;
    logic [2:0]  s_rst_n;
    logic [7:0]  s_uo, s_uio, s_oe;

    tt_project_switch #(.N_PROJ(3), .IO_W(8), .RST_HOLD(2), .DEF_SEL(0)) dut3 (
        .clk(clk), .rst(rst), .sel_req(s_sel_req), .sel_valid(s_sel_valid),
        .sel_ready(s_sel_ready), .sel_err(s_sel_err), .active_sel(s_active_sel),
        .switching(s_switching), .proj_uo_out(s_uo_in), .proj_uio_out(s_uio_in),
        .proj_uio_oe(s_oe_in), .proj_rst_n(s_rst_n), .uo_out(s_uo),
        .uio_out(s_uio), .uio_oe(s_oe)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int n;

    initial begin
        // Project k drives uo=A0|k, uio_out=50|k, uio_oe=F0|k.
        m_uo_in  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        m_uio_in = {8'h53, 8'h52, 8'h51, 8'h50};
        m_oe_in  = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        s_uo_in  = {8'hB2, 8'hB1, 8'hB0};
        s_uio_in = {8'h62, 8'h61, 8'h60};
        s_oe_in  = {8'hE2, 8'hE1, 8'hE0};

        // Reset state.
        tick();
        tick();
        chk("rst_switching", 32'(m_switching), 32'd1);
        chk("rst_ready", 32'(m_sel_ready), 32'd0);
        chk("rst_err", 32'(m_sel_err), 32'd0);
        chk("rst_proj_rst_n", 32'(m_rst_n), 32'd0);
        chk("rst_uo", 32'(m_uo), 32'd0);
        chk("rst_uio", 32'(m_uio), 32'd0);
        chk("rst_oe", 32'(m_oe), 32'd0);
        chk("rst_active_sel", 32'(m_active_sel), 32'd2);

        // Four HOLD cycles after rst falls, then project 2 is live.
        rst = 1'b0;
        chk("hold0_switching", 32'(m_switching), 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("hold%0d_switching", i), 32'(m_switching), 32'd1);
            chk($sformatf("hold%0d_rst_n", i), 32'(m_rst_n), 32'd0);
        end
        tick();
        chk("boot_switching", 32'(m_switching), 32'd0);
        chk("boot_ready", 32'(m_sel_ready), 32'd1);
        chk("boot_rst_n", 32'(m_rst_n), 32'b0100);
        repeat (LAG) tick();
        chk("boot_uo", 32'(m_uo), 32'hA2);
        chk("boot_oe", 32'(m_oe), 32'hF2);

        // Switch 2 -> 1.
        m_sel_req = 2'd1;
        m_sel_valid = 1'b1;
        tick();
        m_sel_valid = 1'b0;
        chk("iso_switching", 32'(m_switching), 32'd1);
        chk("iso_ready", 32'(m_sel_ready), 32'd0);
        chk("iso_rst_n", 32'(m_rst_n), 32'd0);
        chk("iso_oe", 32'(m_oe), 32'd0);
        chk("iso_uo", 32'(m_uo), (LAG != 0) ? 32'hA2 : 32'd0);
        chk("iso_active_sel", 32'(m_active_sel), 32'd2);
        tick();
        chk("sw_hold_active_sel", 32'(m_active_sel), 32'd1);
        chk("sw_hold_uo", 32'(m_uo), 32'd0);
        // A request during HOLD must be ignored.
        m_sel_req = 2'd3;
        m_sel_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("sw_hold%0d_switching", i), 32'(m_switching), 32'd1);
            chk($sformatf("sw_hold%0d_err", i), 32'(m_sel_err), 32'd0);
        end
        tick();
        m_sel_valid = 1'b0;
        chk("sw_active_switching", 32'(m_switching), 32'd0);
        chk("sw_active_rst_n", 32'(m_rst_n), 32'b0010);
        chk("sw_active_sel", 32'(m_active_sel), 32'd1);
        repeat (LAG) tick();
        chk("sw_uo", 32'(m_uo), 32'hA1);
        chk("sw_uio", 32'(m_uio), 32'h51);
        m_uo_in[15:8] = 8'h3C;
        if (LAG != 0) tick(); else #1;
        chk("sw_uo_track", 32'(m_uo), 32'h3C);
        chk("sw_oe_track", 32'(m_oe), 32'hF1);

        // Out-of-range request on the 3-project instance.
        chk("s_pre_active", 32'(s_switching), 32'd0);
        s_sel_req = 2'd3;
        s_sel_valid = 1'b1;
        tick();
        s_sel_valid = 1'b0;
        chk("s_err_pulse", 32'(s_sel_err), 32'd1);
        chk("s_err_active_sel", 32'(s_active_sel), 32'd0);
        chk("s_err_rst_n", 32'(s_rst_n), 32'b001);
        chk("s_err_switching", 32'(s_switching), 32'd0);
        tick();
        chk("s_err_clear", 32'(s_sel_err), 32'd0);
        chk("s_err_rst_n2", 32'(s_rst_n), 32'b001);

        // Restart of the current project 1.
        m_sel_req = 2'd1;
        m_sel_valid = 1'b1;
        tick();
        m_sel_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_rst_n[1] !== 1'b0) break;
            n++;
            tick();
        end
        chk("restart_low_cycles", 32'(n), 32'd5);
        chk("restart_rst_n", 32'(m_rst_n), 32'b0010);
        chk("restart_active_sel", 32'(m_active_sel), 32'd1);

        // Reset during HOLD of a switch to project 3.
        m_sel_req = 2'd3;
        m_sel_valid = 1'b1;
        tick();
        m_sel_valid = 1'b0;
        tick();
        chk("mid_active_sel", 32'(m_active_sel), 32'd3);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_active_sel", 32'(m_active_sel), 32'd2);
        chk("mid_rst_switching", 32'(m_switching), 32'd1);
        chk("mid_rst_rst_n", 32'(m_rst_n), 32'd0);
        chk("mid_rst_uo", 32'(m_uo), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_switching !== 1'b1) break;
            n++;
            tick();
        end
        chk("mid_rehold_cycles", 32'(n), 32'd4);
        chk("mid_rehold_rst_n", 32'(m_rst_n), 32'b0100);
        chk("mid_rehold_sel", 32'(m_active_sel), 32'd2);
        repeat (LAG) tick();
        chk("mid_rehold_uo", 32'(m_uo), 32'hA2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
